inst_fetch_bridge: RTL and testbench
====================================

Name: inst_fetch_bridge

Overview:
Sits directly upstream of the CPU top's instruction port. It answers the core's rom_ce/rom_addr fetch with rom_data from a one-line instruction buffer. On a miss it drives a variable-latency req/ack memory bus and raises a stall request, which ctrl consumes as stallreq_from_if. It also provides a timeout and a buffer flush.

Parameters:
ADDR_W, 32, core/bus address width
DATA_W, 32, instruction width
TIMEOUT_CYC, 255, max cycles bus_req_o stays high without ack; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
rom_ce_i  in  1  core fetch enable
rom_addr_i  in  ADDR_W  core fetch address; bits[1:0] ignored
rom_data_o  out  DATA_W  instruction to core
stallreq_o  out  1  fetch stall request to ctrl
flush_i  in  1  invalidate buffer
bus_req_o  out  1  memory read request (registered)
bus_addr_o  out  ADDR_W  word-aligned read address (registered)
bus_ack_i  in  1  read data valid; sampled only while bus_req_o=1
bus_rdata_i  in  DATA_W  read data
fetch_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Buffer entry: valid, tag = addr[ADDR_W-1:2], data.
- hit = rom_ce_i & valid & (tag == rom_addr_i[ADDR_W-1:2]).
- rom_ce_i=0: rom_data_o=0, stallreq_o=0.
- Hit: rom_data_o = buffer data, combinationally in the same cycle; stallreq_o=0.
- Miss (rom_ce_i & !hit): stallreq_o=1 combinationally; rom_data_o=0.
- FSM states: IDLE, REQ.
- IDLE, on miss with flush_i=0:
  - latch req_addr = {rom_addr_i[ADDR_W-1:2],2'b00};
  - set bus_req_o=1 and bus_addr_o=req_addr at the next edge;
  - clear drop flag and counter; go to REQ.
- REQ:
  - bus_addr_o is held stable while bus_req_o=1.
  - Counter increments each cycle.
  - On an edge with bus_ack_i=1: bus_req_o→0; if drop=0, write {valid=1, tag=req_addr, data=bus_rdata_i}; go to IDLE.
- Minimum miss penalty: 2 stall cycles (ack in the first REQ cycle); the hit is served in the third cycle.
- Timeout: if counter reaches TIMEOUT_CYC with no ack:
  - bus_req_o→0;
  - buffer written with NOP 0x0000_0000 tagged req_addr (unless drop=1);
  - fetch_err_o=1 for exactly one cycle; return to IDLE.
- Core address changes while in REQ: the in-flight request completes with the latched tag, then a new miss is issued for the new address.
- flush_i:
  - valid→0 at the next edge;
  - in REQ it sets drop, so the returning data is discarded;
  - flush_i and ack on the same edge: flush wins, nothing is written;
  - flush_i and a miss in IDLE: no request that cycle; the request issues on the following cycle.
- Reset (async assert):
  - state=IDLE, valid=0, bus_req_o=0, bus_addr_o=0, fetch_err_o=0, counter=0, drop=0;
  - a request pending at reset is abandoned; bus_ack_i after reset is ignored because bus_req_o=0.

Optional Feature:
IFB_PREFETCH_EN defined:
- A second entry, the prefetch line, is added.
- In IDLE with no miss, after any demand fill of address A, issue a request for A+4 into the prefetch line; at most one prefetch per demand fill.
- A hit in either line is zero-stall. A prefetch-line hit copies that line into the demand line, freeing the prefetch line.
- Core miss while a prefetch is in flight:
  - miss address equals the prefetch address: stall until its ack; the fill is served as a demand fill;
  - otherwise: wait for the ack (no abort), discard the data, then issue the demand request.
- Timeout on a prefetch writes nothing and raises no fetch_err_o.
- flush_i invalidates both lines.

IFB_PREFETCH_EN undefined: single line only; the bus is never requested except on a demand miss.

Decomposition:
- Package ifb_pkg holds:
  - the state enum {IFB_IDLE, IFB_REQ};
  - IFB_NOP = 32'h0000_0000;
  - the tag width constant ADDR_W-2;
  - the ZeroWord constant.
- Sub-module ifb_line: one buffer entry (valid/tag/data, write, invalidate, hit compare). It is instantiated once, or twice under IFB_PREFETCH_EN.

Test Plan:
1. Release rst, rom_ce_i=1, addr 0x0000_0100, ack 3 cycles after bus_req_o rises with data 0x3401_1100 -> bus_addr_o=0x100, stallreq_o high 5 cycles, then rom_data_o=0x34011100 with stallreq_o=0.
2. Re-fetch 0x100 -> zero stall, bus_req_o stays 0; fetch 0x104 -> miss, bus_addr_o=0x104.
3. TIMEOUT_CYC=8, never ack -> bus_req_o drops after 8 REQ cycles, fetch_err_o one-cycle pulse, rom_data_o=0 with stallreq_o=0 for that address.
4. flush_i on the same edge as bus_ack_i -> no write; next cycle still a miss; new request for the same address.
5. rst driven low mid-REQ -> bus_req_o=0 immediately (async), buffer invalid; after release the same fetch reissues the request.
6. IFB_PREFETCH_EN: fill 0x200, core idle (rom_ce_i=0) -> bus_addr_o=0x204 requested and acked; then fetch 0x204 -> zero-stall hit.

Source files
------------

// File: rtl/ifb_pkg.sv
// Shared types and constants for the instruction fetch bridge.
// The optional prefetch line is enabled by defining IFB_PREFETCH_EN.
package ifb_pkg;

  typedef enum logic {
    IFB_IDLE = 1'b0,
    IFB_REQ  = 1'b1
  } ifb_state_e;

  localparam logic [31:0] IFB_NOP    = 32'h0000_0000;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam int          IFB_ADDR_W = 32;
  localparam int          IFB_TAG_W  = IFB_ADDR_W - 2;

  // Word tag: the byte-offset bits are dropped.
  function automatic int ifb_tag_w(input int addr_w);
    return addr_w - 2;
  endfunction

  // The timeout counter only has to reach TIMEOUT_CYC-1.
  function automatic int ifb_cnt_w(input int timeout_cyc);
    return (timeout_cyc < 2) ? 1 : $clog2(timeout_cyc);
  endfunction

endpackage

// File: rtl/ifb_line.sv
// One instruction buffer entry: valid/tag/data with write, invalidate and hit compare.
// Invalidate has priority over a write on the same edge.
module ifb_line
  import ifb_pkg::*;
#(
  parameter int TAG_W  = IFB_TAG_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              inv,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
    end else if (inv) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
    end
  end

  // NOTE: tag and data are only ever observed through valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr && !inv) begin
      tag  <= wr_tag;
      data <= wr_data;
    end
  end

  assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: one-line buffer in front of a req/ack bus with stall, timeout and flush.
// Define IFB_PREFETCH_EN to add a next-line prefetch entry.
module inst_fetch_bridge
  import ifb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [DATA_W-1:0] rom_data_o,
  output logic              stallreq_o,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              fetch_err_o
);

  localparam int               TAG_W    = ifb_tag_w(ADDR_W);
  localparam int               CNT_W    = ifb_cnt_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  ifb_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              drop;
  logic              is_pf;
  logic [TAG_W-1:0]  fetch_tag;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              miss;
  logic              timeout;
  logic              bus_done;
  logic              keep;
  logic [DATA_W-1:0] fill_data;
  logic              dem_hit;
  logic              dem_wr;
  logic              dem_inv;
  logic [TAG_W-1:0]  dem_wtag;
  logic [DATA_W-1:0] dem_wdata;
  logic [DATA_W-1:0] dem_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^rom_addr_i[1:0];
  assign fetch_tag        = rom_addr_i[ADDR_W-1:2];
  assign req_tag          = bus_addr_o[ADDR_W-1:2];
  assign timeout          = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);
  // An ack in the same cycle as the timeout still delivers real data.
  assign bus_done         = (state == IFB_REQ) && (bus_ack_i || timeout);
  assign keep             = !(drop || flush_i);
  assign fill_data        = bus_ack_i ? bus_rdata_i : DATA_W'(IFB_NOP);

  ifb_line #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_dem_line (
    .clk        (clk),
    .rst        (rst),
    .wr         (dem_wr),
    .inv        (dem_inv),
    .wr_tag     (dem_wtag),
    .wr_data    (dem_wdata),
    .lookup_tag (fetch_tag),
    .hit        (dem_hit),
    .data       (dem_data)
  );

`ifdef IFB_PREFETCH_EN
  logic              pf_hit;
  logic              pf_wr;
  logic              pf_inv;
  logic              pf_arm;
  logic              pf_copy;
  logic              pf_pending;
  logic [TAG_W-1:0]  pf_next_tag;
  logic [DATA_W-1:0] pf_data;

  ifb_line #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_pf_line (
    .clk        (clk),
    .rst        (rst),
    .wr         (pf_wr),
    .inv        (pf_inv),
    .wr_tag     (req_tag),
    .wr_data    (bus_rdata_i),
    .lookup_tag (fetch_tag),
    .hit        (pf_hit),
    .data       (pf_data)
  );

  assign hit        = rom_ce_i && (dem_hit || pf_hit);
  assign rom_data_o = !rom_ce_i ? DATA_W'(ZeroWord) :
                      dem_hit   ? dem_data :
                      pf_hit    ? pf_data  : DATA_W'(ZeroWord);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    dem_wr    = 1'b0;
    pf_wr     = 1'b0;
    pf_arm    = 1'b0;
    pf_copy   = 1'b0;
    dem_wtag  = req_tag;
    dem_wdata = fill_data;
    if (bus_done && keep) begin
      if (!is_pf) begin
        dem_wr = 1'b1;
        pf_arm = bus_ack_i;
      end else if (bus_ack_i && miss && (fetch_tag == req_tag)) begin
        dem_wr = 1'b1;
        pf_arm = 1'b1;
      end else if (bus_ack_i && !miss) begin
        pf_wr = 1'b1;
      end
    end
    // A prefetch-line hit migrates into the demand line and frees the prefetch line.
    if (rom_ce_i && pf_hit && !dem_hit && !dem_wr && !flush_i) begin
      pf_copy   = 1'b1;
      dem_wr    = 1'b1;
      dem_wtag  = fetch_tag;
      dem_wdata = pf_data;
    end
    dem_inv = flush_i;
    pf_inv  = flush_i || (pf_copy && !pf_wr);
  end
`else
  assign is_pf      = 1'b0;
  assign hit        = rom_ce_i && dem_hit;
  assign rom_data_o = hit ? dem_data : DATA_W'(ZeroWord);
  assign dem_wr     = bus_done && keep;
  assign dem_wtag   = req_tag;
  assign dem_wdata  = fill_data;
  assign dem_inv    = flush_i;
`endif

  assign miss       = rom_ce_i && !hit;
  assign stallreq_o = miss;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IFB_IDLE;
      bus_req_o   <= 1'b0;
      bus_addr_o  <= '0;
      fetch_err_o <= 1'b0;
      cnt         <= '0;
      drop        <= 1'b0;
`ifdef IFB_PREFETCH_EN
      is_pf       <= 1'b0;
      pf_pending  <= 1'b0;
      pf_next_tag <= '0;
`endif
    end else begin
      fetch_err_o <= 1'b0;
      case (state)
        IFB_IDLE: begin
          cnt  <= '0;
          drop <= 1'b0;
          if (miss && !flush_i) begin
            bus_req_o  <= 1'b1;
            bus_addr_o <= {fetch_tag, 2'b00};
            state      <= IFB_REQ;
`ifdef IFB_PREFETCH_EN
            is_pf      <= 1'b0;
          end else if (!miss && pf_pending && !flush_i) begin
            bus_req_o  <= 1'b1;
            bus_addr_o <= {pf_next_tag, 2'b00};
            state      <= IFB_REQ;
            is_pf      <= 1'b1;
            pf_pending <= 1'b0;
`endif
          end
        end
        IFB_REQ: begin
          cnt <= cnt + 1'b1;
          if (flush_i) begin
            drop <= 1'b1;
          end
          if (bus_done) begin
            bus_req_o   <= 1'b0;
            state       <= IFB_IDLE;
            fetch_err_o <= !bus_ack_i && !is_pf;
          end
`ifdef IFB_PREFETCH_EN
          if (pf_arm) begin
            pf_pending  <= 1'b1;
            pf_next_tag <= req_tag + 1'b1;
          end
`endif
        end
        default: state <= IFB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge (default build, IFB_PREFETCH_EN undefined).
// A transaction-level buffer model predicts hit/miss, stall length, bus address and returned data.
module tb_inst_fetch_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = '0;
  logic        flush = 1'b0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] rom_data;
  logic        stallreq;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  // Model of the single buffer line as the core sees it.
  bit          m_valid = 1'b0;
  logic [29:0] m_tag   = '0;
  logic [31:0] m_data  = '0;

  inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_i    (rom_ce),
    .rom_addr_i  (rom_addr),
    .rom_data_o  (rom_data),
    .stallreq_o  (stallreq),
    .flush_i     (flush),
    .bus_req_o   (bus_req),
    .bus_addr_o  (bus_addr),
    .bus_ack_i   (bus_ack),
    .bus_rdata_i (bus_rdata),
    .fetch_err_o (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] addr);
    return m_valid && (m_tag == addr[31:2]);
  endfunction

  // Entered and left at a falling edge. lat = REQ cycle carrying the ack (1..TO); 0 = never ack.
  task automatic fetch(input logic [31:0] addr, input int lat, input logic [31:0] data,
                       input bit fl_ack, input string nm);
    logic [31:0] waddr;
    bit          exp_hit;
    int          stalls;
    waddr    = {addr[31:2], 2'b00};
    rom_ce   = 1'b1;
    rom_addr = addr;
    #1;
    exp_hit = model_hit(addr);
    check($sformatf("%s.stall0", nm), 32'(stallreq), 32'(!exp_hit));
    if (exp_hit) begin
      check($sformatf("%s.hit_data", nm), rom_data, m_data);
      @(posedge clk); #1;
      check($sformatf("%s.hit_no_req", nm), 32'(bus_req), 32'd0);
      @(negedge clk);
      return;
    end
    check($sformatf("%s.miss_data", nm), rom_data, 32'd0);
    stalls = stallreq ? 1 : 0;
    @(posedge clk); #1;
    for (int k = 1; k <= TO; k++) begin
      if (k == lat) begin
        bus_ack   = 1'b1;
        bus_rdata = data;
        flush     = fl_ack;
      end
      @(negedge clk);
      if (stallreq) stalls++;
      check($sformatf("%s.req%0d", nm, k), 32'(bus_req), 32'd1);
      check($sformatf("%s.addr%0d", nm, k), bus_addr, waddr);
      check($sformatf("%s.data%0d", nm, k), rom_data, 32'd0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      flush   = 1'b0;
      if (k == lat) break;
    end
    check($sformatf("%s.req_drop", nm), 32'(bus_req), 32'd0);
    if (lat >= 1 && lat <= TO) begin
      check($sformatf("%s.no_err", nm), 32'(fetch_err), 32'd0);
      check($sformatf("%s.stall_cycles", nm), 32'(stalls), 32'(lat + 1));
      if (fl_ack) begin
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_tag   = addr[31:2];
        m_data  = data;
      end
    end else begin
      check($sformatf("%s.err_pulse", nm), 32'(fetch_err), 32'd1);
      check($sformatf("%s.stall_cycles", nm), 32'(stalls), 32'(TO + 1));
      m_valid = 1'b1;
      m_tag   = addr[31:2];
      m_data  = 32'h0000_0000;
    end
    @(negedge clk);
    exp_hit = model_hit(addr);
    check($sformatf("%s.after_stall", nm), 32'(stallreq), 32'(!exp_hit));
    check($sformatf("%s.after_data", nm), rom_data, exp_hit ? m_data : 32'd0);
    if (!(lat >= 1 && lat <= TO)) begin
      @(posedge clk); #1;
      check($sformatf("%s.err_once", nm), 32'(fetch_err), 32'd0);
      check($sformatf("%s.err_no_req", nm), 32'(bus_req), 32'd0);
      @(negedge clk);
    end
  endtask

  logic [31:0] bases [5] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h300};

  initial begin
    logic [31:0] a;
    int          op;
    int          lat;
    bit          fl;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst.bus_req", 32'(bus_req), 32'd0);
    check("rst.bus_addr", bus_addr, 32'd0);
    check("rst.fetch_err", 32'(fetch_err), 32'd0);
    check("rst.stall_idle", 32'(stallreq), 32'd0);
    check("rst.data_idle", rom_data, 32'd0);
    rom_ce   = 1'b1;
    rom_addr = 32'h100;
    #1;
    check("rst.stall_invalid", 32'(stallreq), 32'd1);
    rom_ce = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 1: first fill with ack in the 4th REQ cycle
    fetch(32'h0000_0100, 4, 32'h3401_1100, 1'b0, "t1");
    // 2: re-fetch hits, next word misses
    fetch(32'h0000_0100, 1, 32'hDEAD_0000, 1'b0, "t2hit");
    fetch(32'h0000_0104, 1, 32'h2001_0004, 1'b0, "t2min");
    // 3: timeout fills NOP, then zero-stall hit on it
    fetch(32'h0000_0400, 0, 32'h0, 1'b0, "t3");
    fetch(32'h0000_0402, 2, 32'hBAD0_BAD0, 1'b0, "t3hit");
    // 4: flush on the ack edge, then the same address re-requests
    fetch(32'h0000_0500, 3, 32'h1111_2222, 1'b1, "t4flush");
    fetch(32'h0000_0500, 2, 32'h3333_4444, 1'b0, "t4refill");
    // 4b: flush together with a miss in idle defers the request by one cycle
    rom_ce   = 1'b1;
    rom_addr = 32'h600;
    flush    = 1'b1;
    #1;
    check("t4b.stall", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    flush   = 1'b0;
    m_valid = 1'b0;
    check("t4b.no_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    fetch(32'h0000_0600, 2, 32'h5555_6666, 1'b0, "t4b");

    // 5: async reset in the middle of a request
    rom_ce   = 1'b1;
    rom_addr = 32'h700;
    @(posedge clk); #1;
    check("t5.req_up", 32'(bus_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5.req_async", 32'(bus_req), 32'd0);
    check("t5.addr_async", bus_addr, 32'd0);
    m_valid = 1'b0;
    @(negedge clk);
    rom_ce = 1'b0;
    @(negedge clk);
    rst     = 1'b1;
    bus_ack = 1'b1;
    @(posedge clk); #1;
    check("t5.ack_ignored", 32'(bus_req), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    check("t5.idle_data", rom_data, 32'd0);
    fetch(32'h0000_0700, 3, 32'h7777_0700, 1'b0, "t5re");
    fetch(32'h0000_0100, 1, 32'h0100_0100, 1'b0, "t5inv");

    // Random mix of fetches, idle cycles with stray acks, and flushes
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
        rom_ce  = 1'b0;
        bus_ack = 1'b1;
        #1;
        check($sformatf("r%0d.idle_stall", i), 32'(stallreq), 32'd0);
        check($sformatf("r%0d.idle_data", i), rom_data, 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        check($sformatf("r%0d.idle_req", i), 32'(bus_req), 32'd0);
        @(negedge clk);
      end else if (op == 1) begin
        rom_ce = 1'b0;
        flush  = 1'b1;
        @(posedge clk); #1;
        flush   = 1'b0;
        m_valid = 1'b0;
        check($sformatf("r%0d.flush_req", i), 32'(bus_req), 32'd0);
        @(negedge clk);
      end else begin
        a   = bases[$urandom_range(0, 4)] | 32'($urandom_range(0, 3));
        lat = (op == 2) ? 0 : $urandom_range(1, 6);
        fl  = (lat != 0) && ($urandom_range(0, 5) == 0);
        fetch(a, lat, $urandom, fl, $sformatf("r%0d", i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
